cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter READ_ONLY, default 0; 1 means the cache never writes back and never sets dirty bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 32; width of the performance counters.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_op  in  1  0=read, 1=write.
- req_ready  out  1  controller accepts a request.
- resp_valid  out  1  request complete, one-cycle pulse.
- valid_block_match  in  1  metadata hit.
- valid_dirty_bit  in  1  selected way valid and dirty.
- miss_recovery_mode  out  1  metadata selects the victim way.
- process_lru_counters  out  1  update LRU for the selected way.
- clear_selected_valid_bit  out  1  invalidate the selected line.
- finish_new_line_install  out  1  set valid and write the tag.
- clear_selected_dirty_bit  out  1  clear dirty on the selected line.
- set_selected_dirty_bit  out  1  mark the selected line dirty.
- mem_req_valid  out  1  memory request.
- mem_req_we  out  1  1=writeback, 0=fill.
- mem_addr_sel  out  1  1=victim tag address, 0=request address.
- mem_req_ready  in  1  memory accepts the request.
- mem_resp_valid  in  1  memory transaction done, one-cycle pulse.
- data_fill_we  out  1  write the fill data into the data array.
- data_store_we  out  1  write the store data into the data array.
- hit_count  out  CNT_WIDTH  hits counted since reset.
- miss_count  out  CNT_WIDTH  misses counted since reset.

Function
REQ-004 SHALL use the states IDLE, COMPARE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, INSTALL.
REQ-005 SHALL drive req_ready=1 only in IDLE; on req_valid&req_ready, SHALL latch req_op and go to COMPARE.
REQ-006 COMPARE with valid_block_match=1 (hit) SHALL, in the same cycle, pulse resp_valid and process_lru_counters, pulse data_store_we and set_selected_dirty_bit if op=write and READ_ONLY=0, then go to IDLE.
- Hit latency: resp_valid one cycle after acceptance.
REQ-007 COMPARE with a miss SHALL go to WB_REQ if valid_dirty_bit=1 and READ_ONLY=0, otherwise to FILL_REQ.
- valid_dirty_bit is sampled with miss_recovery_mode=1, via the one-cycle combinational lookahead described in REQ-008.
REQ-008 miss_recovery_mode SHALL be 1 in WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT and INSTALL.
- It SHALL also be 1 in COMPARE whenever valid_block_match=0, so that valid_dirty_bit refers to the victim way.
REQ-009 WB_REQ SHALL drive mem_req_valid=1, mem_req_we=1, mem_addr_sel=1 until mem_req_ready, then go to WB_WAIT.
REQ-010 WB_WAIT SHALL hold until mem_resp_valid, then pulse clear_selected_dirty_bit and go to FILL_REQ.
REQ-011 On the first FILL_REQ cycle, SHALL pulse clear_selected_valid_bit for one cycle.
- SHALL drive mem_req_valid=1, mem_req_we=0, mem_addr_sel=0 until mem_req_ready, then go to FILL_WAIT.
REQ-012 FILL_WAIT SHALL pulse data_fill_we on the mem_resp_valid cycle and go to INSTALL.
REQ-013 INSTALL SHALL pulse finish_new_line_install and clear_selected_dirty_bit for one cycle, then return to COMPARE to replay the request, which then hits.
REQ-014 mem_req_valid SHALL stay asserted until the handshake completes; mem_resp_valid outside WB_WAIT/FILL_WAIT SHALL be ignored.
REQ-015 clear_selected_valid_bit and finish_new_line_install SHALL never be asserted in the same cycle.
REQ-016 hit_count SHALL increment on each hit from COMPARE excluding replays; miss_count SHALL increment once per COMPARE miss.
- Both counters SHALL saturate at all-ones.
REQ-017 READ_ONLY=1 SHALL make WB_REQ/WB_WAIT unreachable and hold set_selected_dirty_bit=0.

Reset
REQ-018 On reset, SHALL go to IDLE, zero both counters and the latched op, and hold every output 0 except req_ready=1, starting the first cycle after reset.
REQ-019 Reset mid-transaction SHALL abandon it with no further metadata or memory pulses.

Structure
REQ-020 Package cache_pkg SHALL hold the state enum (cache_state_t) and op enum (cache_op_t: OP_READ, OP_WRITE).
REQ-021 SHALL instantiate sub-module sat_counter (parameter WIDTH) twice, for hit_count and miss_count.

Verification
REQ-022 Read hit: valid_block_match=1 -> resp_valid 1 cycle after acceptance, process_lru_counters=1, hit_count=1.
REQ-023 Clean read miss: match=0, dirty=0 -> FILL_REQ, clear_valid pulse; mem_req_ready after 2 cycles, resp after 5 -> install pulse, then replay hit resp; miss_count=1, hit_count=0.
REQ-024 Dirty write miss: dirty=1 -> writeback (we=1, addr_sel=1), then fill; replay asserts set_selected_dirty_bit and data_store_we.
REQ-025 READ_ONLY=1, write miss with dirty=1 -> no mem_req_we=1 ever, no set_dirty.
REQ-026 Reset asserted in FILL_WAIT -> next cycle IDLE, req_ready=1, counters 0; a stray mem_resp_valid is ignored.
REQ-027 Force counters to 2^CNT_WIDTH-1 (CNT_WIDTH=4, 16 hits) -> hit_count stays 15.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the cache controller: FSM states and the latched CPU operation.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WB_REQ,
        WB_WAIT,
        FILL_REQ,
        FILL_WAIT,
        INSTALL
    } cache_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } cache_op_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Blocking cache controller: hit/miss decision, optional writeback, line fill and replay,
// plus saturating hit/miss performance counters.
module cache_controller
    import cache_pkg::*;
#(
    parameter int READ_ONLY = 0,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_op,
    output logic                 req_ready,
    output logic                 resp_valid,
    input  logic                 valid_block_match,
    input  logic                 valid_dirty_bit,
    output logic                 miss_recovery_mode,
    output logic                 process_lru_counters,
    output logic                 clear_selected_valid_bit,
    output logic                 finish_new_line_install,
    output logic                 clear_selected_dirty_bit,
    output logic                 set_selected_dirty_bit,
    output logic                 mem_req_valid,
    output logic                 mem_req_we,
    output logic                 mem_addr_sel,
    input  logic                 mem_req_ready,
    input  logic                 mem_resp_valid,
    output logic                 data_fill_we,
    output logic                 data_store_we,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    cache_state_t state;
    cache_op_t    op_q;
    logic         replay_q;
    logic         fill_first_q;
    logic         can_write;
    logic         hit_evt;
    logic         miss_evt;

    assign can_write = (READ_ONLY == 0);
    assign hit_evt   = !reset && (state == COMPARE) && valid_block_match && !replay_q;
    assign miss_evt  = !reset && (state == COMPARE) && !valid_block_match;

    // replay_q marks the COMPARE that follows INSTALL so its hit is not counted twice;
    // fill_first_q is high only on the entry cycle of FILL_REQ.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= OP_READ;
            replay_q     <= 1'b0;
            fill_first_q <= 1'b0;
        end else begin
            fill_first_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q     <= cache_op_t'(req_op);
                        replay_q <= 1'b0;
                        state    <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (valid_block_match) begin
                        state <= IDLE;
                    end else if (valid_dirty_bit && can_write) begin
                        state <= WB_REQ;
                    end else begin
                        state        <= FILL_REQ;
                        fill_first_q <= 1'b1;
                    end
                end
                WB_REQ: begin
                    if (mem_req_ready) state <= WB_WAIT;
                end
                WB_WAIT: begin
                    if (mem_resp_valid) begin
                        state        <= FILL_REQ;
                        fill_first_q <= 1'b1;
                    end
                end
                FILL_REQ: begin
                    if (mem_req_ready) state <= FILL_WAIT;
                end
                FILL_WAIT: begin
                    if (mem_resp_valid) state <= INSTALL;
                end
                INSTALL: begin
                    state    <= COMPARE;
                    replay_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs react to the metadata and memory inputs in the same cycle; all of them are
    // suppressed while reset is high so an abandoned transaction emits nothing further.
    always_comb begin
        req_ready                = 1'b0;
        resp_valid               = 1'b0;
        miss_recovery_mode       = 1'b0;
        process_lru_counters     = 1'b0;
        clear_selected_valid_bit = 1'b0;
        finish_new_line_install  = 1'b0;
        clear_selected_dirty_bit = 1'b0;
        set_selected_dirty_bit   = 1'b0;
        mem_req_valid            = 1'b0;
        mem_req_we               = 1'b0;
        mem_addr_sel             = 1'b0;
        data_fill_we             = 1'b0;
        data_store_we            = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: req_ready = 1'b1;
                COMPARE: begin
                    if (valid_block_match) begin
                        resp_valid           = 1'b1;
                        process_lru_counters = 1'b1;
                        if ((op_q == OP_WRITE) && can_write) begin
                            data_store_we          = 1'b1;
                            set_selected_dirty_bit = 1'b1;
                        end
                    end else begin
                        miss_recovery_mode = 1'b1;
                    end
                end
                WB_REQ: begin
                    miss_recovery_mode = 1'b1;
                    mem_req_valid      = 1'b1;
                    mem_req_we         = 1'b1;
                    mem_addr_sel       = 1'b1;
                end
                WB_WAIT: begin
                    miss_recovery_mode       = 1'b1;
                    clear_selected_dirty_bit = mem_resp_valid;
                end
                FILL_REQ: begin
                    miss_recovery_mode       = 1'b1;
                    mem_req_valid            = 1'b1;
                    clear_selected_valid_bit = fill_first_q;
                end
                FILL_WAIT: begin
                    miss_recovery_mode = 1'b1;
                    data_fill_we       = mem_resp_valid;
                end
                INSTALL: begin
                    miss_recovery_mode       = 1'b1;
                    finish_new_line_install  = 1'b1;
                    clear_selected_dirty_bit = 1'b1;
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (hit_evt),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (miss_evt),
        .count (miss_count)
    );

endmodule

// File: tb/tb_cache_controller.sv
// Randomized self-checking bench: a writable (4-bit counters) and a read-only (8-bit counters)
// controller share stimulus; only the selected one ever sees req_valid.
module tb_cache_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0;
    logic req_op = 1'b0;
    logic valid_block_match = 1'b0;
    logic mem_req_ready = 1'b0;
    logic mem_resp_valid = 1'b0;
    logic dirty_meta = 1'b0;
    logic valid_dirty_bit;
    bit   sel_ro = 1'b0;

    logic req_valid_rw, req_valid_ro;
    logic req_ready_rw, resp_valid_rw, mode_rw, lru_rw, clrv_rw, fin_rw, clrd_rw, setd_rw;
    logic mreqv_rw, mwe_rw, masel_rw, fill_rw, store_rw;
    logic req_ready_ro, resp_valid_ro, mode_ro, lru_ro, clrv_ro, fin_ro, clrd_ro, setd_ro;
    logic mreqv_ro, mwe_ro, masel_ro, fill_ro, store_ro;
    logic [3:0] hit_rw, miss_rw;
    logic [7:0] hit_ro, miss_ro;

    logic        obs_req_ready, obs_resp_valid, obs_mode, obs_lru, obs_clrv, obs_fin, obs_clrd;
    logic        obs_setd, obs_mreqv, obs_mwe, obs_masel, obs_fill, obs_store;
    logic [11:0] obs_others;
    logic [31:0] obs_hit, obs_miss;

    int checks_total = 0;
    int checks_passed = 0;
    int model_hits[2];
    int model_misses[2];
    int model_cap[2];

    always #5 clk = ~clk;

    assign req_valid_rw    = req_valid & ~sel_ro;
    assign req_valid_ro    = req_valid & sel_ro;
    assign valid_dirty_bit = dirty_meta & obs_mode;

    assign obs_req_ready  = sel_ro ? req_ready_ro  : req_ready_rw;
    assign obs_resp_valid = sel_ro ? resp_valid_ro : resp_valid_rw;
    assign obs_mode       = sel_ro ? mode_ro       : mode_rw;
    assign obs_lru        = sel_ro ? lru_ro        : lru_rw;
    assign obs_clrv       = sel_ro ? clrv_ro       : clrv_rw;
    assign obs_fin        = sel_ro ? fin_ro        : fin_rw;
    assign obs_clrd       = sel_ro ? clrd_ro       : clrd_rw;
    assign obs_setd       = sel_ro ? setd_ro       : setd_rw;
    assign obs_mreqv      = sel_ro ? mreqv_ro      : mreqv_rw;
    assign obs_mwe        = sel_ro ? mwe_ro        : mwe_rw;
    assign obs_masel      = sel_ro ? masel_ro      : masel_rw;
    assign obs_fill       = sel_ro ? fill_ro       : fill_rw;
    assign obs_store      = sel_ro ? store_ro      : store_rw;
    assign obs_hit        = sel_ro ? {24'b0, hit_ro}  : {28'b0, hit_rw};
    assign obs_miss       = sel_ro ? {24'b0, miss_ro} : {28'b0, miss_rw};
    assign obs_others     = {obs_resp_valid, obs_mode, obs_lru, obs_clrv, obs_fin, obs_clrd,
                             obs_setd, obs_mreqv, obs_mwe, obs_masel, obs_fill, obs_store};

    cache_controller #(.READ_ONLY(0), .CNT_WIDTH(4)) dut_rw (
        .clk(clk), .reset(reset), .req_valid(req_valid_rw), .req_op(req_op),
        .req_ready(req_ready_rw), .resp_valid(resp_valid_rw),
        .valid_block_match(valid_block_match), .valid_dirty_bit(valid_dirty_bit),
        .miss_recovery_mode(mode_rw), .process_lru_counters(lru_rw),
        .clear_selected_valid_bit(clrv_rw), .finish_new_line_install(fin_rw),
        .clear_selected_dirty_bit(clrd_rw), .set_selected_dirty_bit(setd_rw),
        .mem_req_valid(mreqv_rw), .mem_req_we(mwe_rw), .mem_addr_sel(masel_rw),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .data_fill_we(fill_rw), .data_store_we(store_rw),
        .hit_count(hit_rw), .miss_count(miss_rw)
    );

    cache_controller #(.READ_ONLY(1), .CNT_WIDTH(8)) dut_ro (
        .clk(clk), .reset(reset), .req_valid(req_valid_ro), .req_op(req_op),
        .req_ready(req_ready_ro), .resp_valid(resp_valid_ro),
        .valid_block_match(valid_block_match), .valid_dirty_bit(valid_dirty_bit),
        .miss_recovery_mode(mode_ro), .process_lru_counters(lru_ro),
        .clear_selected_valid_bit(clrv_ro), .finish_new_line_install(fin_ro),
        .clear_selected_dirty_bit(clrd_ro), .set_selected_dirty_bit(setd_ro),
        .mem_req_valid(mreqv_ro), .mem_req_we(mwe_ro), .mem_addr_sel(masel_ro),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .data_fill_we(fill_ro), .data_store_we(store_ro),
        .hit_count(hit_ro), .miss_count(miss_ro)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ready"}, obs_req_ready, 1);
        checkOutput({tag, "_outputs"}, obs_others, 0);
        checkOutput({tag, "_hits"}, obs_hit, model_hits[sel_ro]);
        checkOutput({tag, "_misses"}, obs_miss, model_misses[sel_ro]);
    endtask

    // One CPU request from acceptance to response; a reactive memory grants after rd extra
    // cycles and responds sd cycles after the handshake. Expectations come from the rules alone.
    task automatic applyStimulus(input bit ro, input bit op, input bit match, input bit dirty,
                                 input int rd, input int sd);
        bit match_now, waiting, done, wb;
        int cyc, rcnt, wcnt, resp_cyc, clrv_cyc, first_fill;
        int n_lru, n_setd, n_store, n_fill, n_clrv, n_fin, n_clrd, n_we, n_rdreq;
        int n_sel_bad, n_overlap, n_mode_bad, n_ready;
        int exp_lat, phases;
        sel_ro = ro;
        dirty_meta = dirty;
        match_now = match;
        waiting = 0; done = 0; rcnt = 0; wcnt = 0; cyc = 0;
        resp_cyc = -1; clrv_cyc = -1; first_fill = -1;
        n_lru = 0; n_setd = 0; n_store = 0; n_fill = 0; n_clrv = 0; n_fin = 0; n_clrd = 0;
        n_we = 0; n_rdreq = 0; n_sel_bad = 0; n_overlap = 0; n_mode_bad = 0; n_ready = 0;
        @(negedge clk);
        req_valid = 1; req_op = op; valid_block_match = match_now;
        mem_req_ready = 0; mem_resp_valid = 0;
        #1;
        checkOutput("accept_ready", obs_req_ready, 1);
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            req_valid = 0; req_op = ~op; valid_block_match = match_now;
            mem_req_ready = 0; mem_resp_valid = 0;
            if (waiting) begin
                if (wcnt == sd) begin
                    mem_resp_valid = 1;
                    waiting = 0;
                end else begin
                    wcnt++;
                end
            end
            #1;
            if (obs_mreqv && rcnt == rd) mem_req_ready = 1;
            #1;
            if (obs_lru) n_lru++;
            if (obs_setd) n_setd++;
            if (obs_store) n_store++;
            if (obs_fill) n_fill++;
            if (obs_clrv) begin n_clrv++; clrv_cyc = cyc; end
            if (obs_fin) n_fin++;
            if (obs_clrd) n_clrd++;
            if (obs_req_ready) n_ready++;
            if (obs_clrv && obs_fin) n_overlap++;
            if ((obs_mreqv || obs_clrv || obs_fin || obs_fill) && !obs_mode) n_mode_bad++;
            if (obs_mreqv) begin
                if (obs_masel !== obs_mwe) n_sel_bad++;
                if (obs_mwe) n_we++;
                else begin
                    n_rdreq++;
                    if (first_fill < 0) first_fill = cyc;
                end
                if (mem_req_ready) begin
                    waiting = 1; wcnt = 0; rcnt = 0;
                end else begin
                    rcnt++;
                end
            end
            if (obs_fin) match_now = 1;
            if (obs_clrd) dirty_meta = 0;
            if (obs_resp_valid) begin
                done = 1;
                resp_cyc = cyc;
            end
        end
        wb = !match && dirty && !ro;
        phases = wb ? 2 : 1;
        exp_lat = match ? 1 : 3 + phases * (rd + sd + 2);
        if (match) begin
            if (model_hits[ro] < model_cap[ro]) model_hits[ro]++;
        end else begin
            if (model_misses[ro] < model_cap[ro]) model_misses[ro]++;
        end
        checkOutput("resp_seen", done, 1);
        checkOutput("latency", resp_cyc, exp_lat);
        checkOutput("lru_pulses", n_lru, 1);
        checkOutput("set_dirty", n_setd, (op && !ro) ? 1 : 0);
        checkOutput("store_we", n_store, (op && !ro) ? 1 : 0);
        checkOutput("fill_we", n_fill, match ? 0 : 1);
        checkOutput("clear_valid", n_clrv, match ? 0 : 1);
        checkOutput("install", n_fin, match ? 0 : 1);
        checkOutput("clear_dirty", n_clrd, match ? 0 : (wb ? 2 : 1));
        checkOutput("wb_req_cycles", n_we, wb ? rd + 1 : 0);
        checkOutput("fill_req_cycles", n_rdreq, match ? 0 : rd + 1);
        if (!match) checkOutput("clear_valid_cycle", clrv_cyc, 2 + (wb ? rd + sd + 2 : 0));
        checkOutput("addr_sel", n_sel_bad, 0);
        checkOutput("valid_install_overlap", n_overlap, 0);
        checkOutput("recovery_mode", n_mode_bad, 0);
        checkOutput("ready_busy", n_ready, 0);
        @(negedge clk);
        req_valid = 0; valid_block_match = 0; mem_req_ready = 0; mem_resp_valid = 0;
        #1;
        checkIdle("after_txn");
    endtask

    task automatic resetDuringFill();
        bit found;
        sel_ro = 0;
        dirty_meta = 0;
        found = 0;
        @(negedge clk);
        req_valid = 1; req_op = 0; valid_block_match = 0;
        #2;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            req_valid = 0; mem_req_ready = 0;
            #1;
            if (obs_mreqv && !obs_mwe) begin
                mem_req_ready = 1;
                found = 1;
            end
            #1;
        end
        checkOutput("fill_req_seen", found, 1);
        @(negedge clk);
        mem_req_ready = 0; reset = 1; mem_resp_valid = 1;
        @(negedge clk);
        reset = 0;
        model_hits = '{0, 0};
        model_misses = '{0, 0};
        #1;
        checkIdle("post_reset");
        @(negedge clk);
        #1;
        checkIdle("stray_resp");
        mem_resp_valid = 0;
    endtask

    initial begin
        model_hits = '{0, 0};
        model_misses = '{0, 0};
        model_cap = '{15, 255};
        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel_ro = s[0];
            #1;
            checkIdle("reset_state");
        end

        $display("[TB] directed transactions");
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 2, 4);
        applyStimulus(0, 1, 0, 1, 1, 2);
        applyStimulus(1, 1, 0, 1, 1, 1);
        applyStimulus(1, 1, 1, 0, 0, 0);

        $display("[TB] random transactions");
        for (int i = 0; i < 40; i++) begin
            applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 4));
        end

        $display("[TB] reset during fill");
        resetDuringFill();

        $display("[TB] counter saturation");
        for (int i = 0; i < 18; i++) applyStimulus(0, $urandom_range(0, 1), 1, 0, 0, 0);
        sel_ro = 0;
        #1;
        checkOutput("hit_saturated", obs_hit, 15);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got 1, expected 0");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
